// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the CPU core, the program-image builder and the
// memory responder: default bus geometry, opcode and condition-code
// constants, the responder state encoding, and an address range helper.
package cpu_pkg;

  // Default bus geometry
  localparam int CPU_BUSW   = 32;    // data word width
  localparam int CPU_MINDW  = 12;    // word-index width
  localparam int CPU_MWORDS = 4096;  // implemented words (<= 2**CPU_MINDW)

  // Opcodes
  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] LD  = 4'd1;
  localparam logic [3:0] ST  = 4'd2;
  localparam logic [3:0] MOV = 4'd3;
  localparam logic [3:0] ADD = 4'd4;
  localparam logic [3:0] SUB = 4'd5;
  localparam logic [3:0] AND = 4'd6;
  localparam logic [3:0] OR  = 4'd7;
  localparam logic [3:0] XOR = 4'd8;
  localparam logic [3:0] SHL = 4'd9;
  localparam logic [3:0] SHR = 4'd10;
  localparam logic [3:0] JMP = 4'd11;
  localparam logic [3:0] JCC = 4'd12;
  localparam logic [3:0] CMP = 4'd13;

  // Condition codes
  localparam logic [3:0] CC_A  = 4'd0;  // always
  localparam logic [3:0] CC_EQ = 4'd1;
  localparam logic [3:0] CC_NE = 4'd2;
  localparam logic [3:0] CC_LT = 4'd3;
  localparam logic [3:0] CC_GE = 4'd4;
  localparam logic [3:0] CC_CS = 4'd5;  // carry set
  localparam logic [3:0] CC_CC = 4'd6;  // carry clear
  localparam logic [3:0] CC_PE = 4'd7;  // parity even
  localparam logic [3:0] CC_PO = 4'd8;  // parity odd

  // Memory responder state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rsp_state_e;

  // True when a word index addresses an implemented word. Addresses past the
  // end never alias back into the array.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned words);
    return addr < words;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array
// MWORDS x BUSW word store with one synchronous write port and one
// asynchronous read port. Out-of-range writes are dropped and out-of-range
// reads return 0. Contents are not reset.
//
// Ports:
//   clk    in   rising-edge clock
//   we     in   write strobe
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  read data (combinational)
module mem_word_array
  import cpu_pkg::*;
#(
  parameter int BUSW   = CPU_BUSW,
  parameter int MINDW  = CPU_MINDW,
  parameter int MWORDS = CPU_MWORDS
) (
  input  logic             clk,
  input  logic             we,
  input  logic [MINDW-1:0] waddr,
  input  logic [BUSW-1:0]  wdata,
  input  logic [MINDW-1:0] raddr,
  output logic [BUSW-1:0]  rdata
);

  localparam int AW = (MWORDS > 1) ? $clog2(MWORDS) : 1;

  logic [BUSW-1:0] mem_q [MWORDS];
  logic            w_ok;
  logic            r_ok;

  // Range checks use the full index so high bits can never fold onto low words.
  assign w_ok = addr_in_range(32'(waddr), MWORDS);
  assign r_ok = addr_in_range(32'(raddr), MWORDS);

  always_ff @(posedge clk) begin
    if (we && w_ok) begin
      mem_q[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = r_ok ? mem_q[raddr[AW-1:0]] : '0;

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Word-addressed memory slave for instruction fetch, load and store traffic
// with LAT programmable wait states and a side-band preload port.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where rsp_valid
// and rsp_ready are both 1. Payloads (req_* / rsp_rdata, rsp_err) are only
// meaningful while the matching valid is 1, and a response holds stable until
// it transfers. req_ready never looks at req_valid.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_we, req_addr, req_wdata    request payload (1 = store)
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             response payload
//   ld_en, ld_addr, ld_data        preload write port (effective in IDLE)
//   dbg_state                      current FSM state (rsp_state_e encoding)
module cpu_mem_responder
  import cpu_pkg::*;
#(
  parameter int BUSW   = CPU_BUSW,
  parameter int MINDW  = CPU_MINDW,
  parameter int MWORDS = CPU_MWORDS,
  parameter int LAT    = 2           // 0..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [MINDW-1:0] req_addr,
  input  logic [BUSW-1:0]  req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [BUSW-1:0]  rsp_rdata,
  output logic             rsp_err,
  input  logic             ld_en,
  input  logic [MINDW-1:0] ld_addr,
  input  logic [BUSW-1:0]  ld_data,
  output logic [1:0]       dbg_state
);

  rsp_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [MINDW-1:0] addr_q, addr_d;
  logic [BUSW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic             accept;
  logic             mem_we;
  logic [MINDW-1:0] mem_waddr;
  logic [BUSW-1:0]  mem_wdata;
  logic [MINDW-1:0] mem_raddr;
  logic [BUSW-1:0]  mem_rdata;
  logic             rd_we;
  logic             rd_ok;
  logic [BUSW-1:0]  load_rdata;

  assign req_ready = (state_q == IDLE) && !ld_en && rst_n;
  assign accept    = req_valid && req_ready;

  // Single write port: preload has priority, otherwise a store commits on its
  // acceptance edge. Stores are never deferred, so wdata is not held past
  // acceptance.
  assign mem_we    = rst_n && (state_q == IDLE) && (ld_en || (req_valid && req_we));
  assign mem_waddr = ld_en ? ld_addr : req_addr;
  assign mem_wdata = ld_en ? ld_data : req_wdata;

  // With LAT == 0 the response is built on the acceptance edge, before the
  // request latch holds anything, so the live request feeds the read port.
  assign mem_raddr = (state_q == IDLE) ? req_addr : addr_q;
  assign rd_we     = (state_q == IDLE) ? req_we   : we_q;
  assign rd_ok     = addr_in_range(32'(mem_raddr), MWORDS);
  assign load_rdata = (!rd_we && rd_ok) ? mem_rdata : '0;

  mem_word_array #(
    .BUSW   (BUSW),
    .MINDW  (MINDW),
    .MWORDS (MWORDS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d   = req_we;
          addr_d = req_addr;
          if (LAT == 0) begin
            state_d     = RESP;
            rsp_err_d   = !rd_ok;
            rsp_rdata_d = load_rdata;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LAT);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = RESP;
          cnt_d       = 4'd0;
          rsp_err_d   = !rd_ok;
          rsp_rdata_d = load_rdata;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule
